// File: rtl/char_fifo_fwft.sv
// First-word-fall-through character FIFO feeding the UART transmitter.
// Define CHAR_FIFO_OVF_EN to add the sticky char_fifo_ovf dropped-write flag.
module char_fifo_fwft #(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic       clk_tx,
   input  logic       rst_clk_tx,
   input  logic [7:0] char_fifo_din,
   input  logic       char_fifo_wr_en,
   output logic       char_fifo_full,
   output logic       char_fifo_empty,
   output logic [7:0] char_fifo_dout,
`ifdef CHAR_FIFO_OVF_EN
   output logic       char_fifo_ovf,
`endif
   input  logic       char_fifo_rd_en
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [7:0]          mem [DEPTH];
   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic                wr_accept;
   logic                rd_accept;

   // Extra pointer MSB distinguishes full from empty when the addresses match.
   always_comb begin
      char_fifo_empty = (wr_ptr == rd_ptr);
      char_fifo_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
      wr_accept       = char_fifo_wr_en && !char_fifo_full;
      rd_accept       = char_fifo_rd_en && !char_fifo_empty;
      char_fifo_dout  = char_fifo_empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
   end

   always_ff @(posedge clk_tx) begin
      if (rst_clk_tx) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage is not reset; the write is gated so a reset cycle leaves it untouched.
   always_ff @(posedge clk_tx) begin
      if (!rst_clk_tx && wr_accept) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= char_fifo_din;
      end
   end

`ifdef CHAR_FIFO_OVF_EN
   always_ff @(posedge clk_tx) begin
      if (rst_clk_tx) begin
         char_fifo_ovf <= 1'b0;
      end else if (char_fifo_wr_en && char_fifo_full) begin
         char_fifo_ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_char_fifo_fwft.sv
// Directed bench for char_fifo_fwft: vector table plus fill/wrap/reset sequences.
// Define CHAR_FIFO_OVF_EN to also exercise the overflow flag.
module tb_char_fifo_fwft;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       wr_en;
   logic       rd_en;
   logic       full;
   logic       empty;
   logic [7:0] dout;
`ifdef CHAR_FIFO_OVF_EN
   logic       ovf;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   char_fifo_fwft #(.ADDR_WIDTH(4)) dut (
      .clk_tx          (clk),
      .rst_clk_tx      (rst),
      .char_fifo_din   (din),
      .char_fifo_wr_en (wr_en),
      .char_fifo_full  (full),
      .char_fifo_empty (empty),
      .char_fifo_dout  (dout),
`ifdef CHAR_FIFO_OVF_EN
      .char_fifo_ovf   (ovf),
`endif
      .char_fifo_rd_en (rd_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       wr;
      logic       rd;
      logic [7:0] din;
      logic       e;
      logic       f;
      logic [7:0] dout;
   } vec_t;

   vec_t tbl [15];
   logic [7:0] q [$];

   task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
      @(negedge clk);
      rst   = r;
      wr_en = w;
      rd_en = rd;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_state(input string name, input logic e, input logic f, input logic [7:0] d);
      chk1({name, "_empty"}, empty, e);
      chk1({name, "_full"}, full, f);
      chk8({name, "_dout"}, dout, d);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;

      // rst wr rd din    empty full dout
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 8'h41};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h7A, 1'b0, 1'b0, 8'h7A};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h11};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'h22};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
         chk_state($sformatf("vec%0d", i), tbl[i].e, tbl[i].f, tbl[i].dout);
      end
`ifdef CHAR_FIFO_OVF_EN
      chk1("ovf_clear_initially", ovf, 1'b0);
`endif

      // Fill to full, then overflow attempts
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'h30 + 8'(i));
         if (i == 14) chk1("fill15_full", full, 1'b0);
      end
      chk_state("fill16", 1'b0, 1'b1, 8'h30);
      step(1'b0, 1'b1, 1'b0, 8'h55);
      chk_state("drop17", 1'b0, 1'b1, 8'h30);
`ifdef CHAR_FIFO_OVF_EN
      chk1("ovf_set", ovf, 1'b1);
`endif
      // Write while full with a concurrent pop: write dropped, pop taken
      step(1'b0, 1'b1, 1'b1, 8'h55);
      chk_state("drop_with_pop", 1'b0, 1'b0, 8'h31);
      for (int i = 1; i < 16; i++) begin
         chk8($sformatf("drain_%0d", i), dout, 8'h30 + 8'(i));
         step(1'b0, 1'b0, 1'b1, 8'h00);
      end
      chk_state("drained", 1'b1, 1'b0, 8'h00);
`ifdef CHAR_FIFO_OVF_EN
      chk1("ovf_sticky", ovf, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk1("ovf_reset", ovf, 1'b0);
`endif

      // 15 held, then 20 simultaneous push/pop cycles across pointer wrap
      step(1'b1, 1'b0, 1'b0, 8'h00);
      q = {};
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'(i));
         q.push_back(8'(i));
      end
      chk_state("hold15", 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b1, 8'h80 + 8'(i));
         q.push_back(8'h80 + 8'(i));
         void'(q.pop_front());
         chk_state($sformatf("rw%0d", i), 1'b0, 1'b0, q[0]);
      end
      for (int i = 0; i < 15; i++) begin
         chk8($sformatf("wrap_drain_%0d", i), dout, q.pop_front());
         step(1'b0, 1'b0, 1'b1, 8'h00);
      end
      chk_state("wrap_empty", 1'b1, 1'b0, 8'h00);

      // Reset mid-operation with write and read presented
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
      chk_state("fill10", 1'b0, 1'b0, 8'hA0);
      step(1'b1, 1'b1, 1'b1, 8'hEE);
      chk_state("mid_reset", 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk_state("post_reset_idle", 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h5C);
      chk_state("post_reset_write", 1'b0, 1'b0, 8'h5C);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk_state("post_reset_pop", 1'b1, 1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/char_fifo_fwft.md
CHAR_FIFO_FWFT -- requirements
Module: char_fifo_fwft

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, meaning log2 of storage depth (depth = 2**ADDR_WIDTH = 16 entries).
REQ-002 The block SHALL have port clk_tx, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_clk_tx, input, 1, meaning a synchronous, active-high reset.
REQ-004 The block SHALL have port char_fifo_din, input, 8, meaning the character to be written.
REQ-005 The block SHALL have port char_fifo_wr_en, input, 1, meaning the push request.
REQ-006 The block SHALL have port char_fifo_full, output, 1, meaning no free entry.
REQ-007 The block SHALL have port char_fifo_empty, output, 1, meaning no valid entry.
REQ-008 The block SHALL have port char_fifo_dout, output, 8, meaning the head character, valid whenever char_fifo_empty=0 (first-word-fall-through).
REQ-009 The block SHALL have port char_fifo_rd_en, input, 1, meaning pop of the head (driven by the UART transmit controller).

Function
REQ-010 Storage SHALL be 2**ADDR_WIDTH x 8; read and write pointers SHALL be ADDR_WIDTH+1 bits, incrementing modulo 2**(ADDR_WIDTH+1).
REQ-011 empty SHALL be 1 when pointers are equal; full SHALL be 1 when the low ADDR_WIDTH bits match and the MSBs differ; both are combinational decodes of registered pointers.
REQ-012 A write SHALL be accepted iff wr_en=1 and full=0; an accepted write stores din at wr_ptr and increments wr_ptr.
REQ-013 A write with full=1 SHALL be dropped with no state change, even if a pop occurs in the same cycle.
REQ-014 A read SHALL be accepted iff rd_en=1 and empty=0; it increments rd_ptr; rd_en with empty=1 SHALL be ignored.
REQ-015 Simultaneous accepted read and write SHALL leave occupancy unchanged and SHALL not alter full/empty.
REQ-016 Latency: a write to an empty FIFO at edge N SHALL make empty=0 with dout=that character immediately after edge N.
REQ-017 After an accepted pop at edge N, dout SHALL present the next entry immediately after edge N, or empty SHALL assert if none remains.
REQ-018 dout SHALL be 8'h00 whenever empty=1.
REQ-019 Data SHALL leave in exact write order across pointer wrap-around.

Reset
REQ-020 While rst_clk_tx=1 at a clock edge, both pointers SHALL clear to 0, giving empty=1, full=0, dout=8'h00; storage contents need not be cleared.
REQ-021 Reset mid-operation SHALL discard all stored characters; a read or write presented in the reset cycle SHALL be ignored.

Configuration
REQ-022 With macro CHAR_FIFO_OVF_EN defined, the block SHALL add output char_fifo_ovf (1 bit), a sticky flag set on the edge where wr_en=1 and full=1, cleared only by reset.
REQ-023 Without CHAR_FIFO_OVF_EN, char_fifo_ovf SHALL not exist and dropped writes SHALL be silent; all other behaviour is identical.

Verification
REQ-024 Reset, then write 8'h41 one cycle -> empty=0, dout=8'h41 the next cycle; pulse rd_en -> empty=1, dout=8'h00.
REQ-025 Write 16 characters 8'h30..8'h3F without reads -> full=1 after 16th; 17th write 8'h55 dropped; pop 16 -> 8'h30..8'h3F in order, then empty=1.
REQ-026 With 15 entries held, assert wr_en and rd_en together for 20 cycles -> full and empty never toggle, order preserved through pointer wrap.
REQ-027 rd_en held high on empty FIFO for 5 cycles, then one write 8'h7A -> pointers unchanged during empty, 8'h7A visible and popped on the following cycle.
REQ-028 Fill 10 entries, assert rst_clk_tx one cycle with wr_en=1 -> empty=1, full=0, dout=8'h00 after reset; no entry survives.
REQ-029 With CHAR_FIFO_OVF_EN: fill to full, one extra write -> char_fifo_ovf=1 and stays 1 after draining; reset clears it to 0.
